r200hazctl: RTL

Pipeline interlock and forwarding controller for the r200 core, sitting beside the ID stage. It tracks the destination register of every instruction in EX, MEM and WB and compares it with the operands of the instruction in ID. From that it generates forwarding selects, load-use stalls, memory-busy freezes and branch/jump flushes. It sequences the decode stage (regfile reads, op1/op2 muxes) without touching the datapath itself.

---
 rtl/r200_pkg.sv | 24 ++
 rtl/r200hazctl_if.sv | 33 +++
 rtl/r200hzmatch.sv | 29 ++
 rtl/r200hazctl.sv | 77 +++++++
 4 files changed

// File: rtl/r200_pkg.sv
// Shared types for the r200 interlock/forwarding controller:
// forwarding-select encoding and per-stage destination tracking record.
package r200_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwr;
    logic       isload;
  } trk_t;

  // x0 is hardwired, so a write to it can never create a dependency
  function automatic logic trk_hit(trk_t t, logic [4:0] addr, logic uses, logic id_valid);
    return t.valid & t.regwr & (t.rd == addr) & (addr != 5'd0) & uses & id_valid;
  endfunction

endpackage

// File: rtl/r200hazctl_if.sv
// ID-stage hazard bundle: decoded operand/destination info in, pipeline
// stall/flush controls and forwarding selects out.
interface r200hazctl_if;
  logic       id_valid;
  logic [4:0] id_rs1addr;
  logic [4:0] id_rs2addr;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_regwr;
  logic [4:0] id_rdaddr;
  logic       id_isload;
  logic       id_willjmp;
  logic       ex_brtaken;
  logic       mem_busy;
  logic       stall_if;
  logic       stall_id;
  logic       flush_if;
  logic       flush_id;
  logic [1:0] fwd1sel;
  logic [1:0] fwd2sel;

  modport master (
    output id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
           id_regwr, id_rdaddr, id_isload, id_willjmp, ex_brtaken, mem_busy,
    input  stall_if, stall_id, flush_if, flush_id, fwd1sel, fwd2sel
  );

  modport slave (
    input  id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
           id_regwr, id_rdaddr, id_isload, id_willjmp, ex_brtaken, mem_busy,
    output stall_if, stall_id, flush_if, flush_id, fwd1sel, fwd2sel
  );
endinterface

// File: rtl/r200hzmatch.sv
// Single-operand hazard matcher: picks the youngest producer (EX > MEM > WB)
// and flags a load still in EX, which cannot be forwarded yet.
module r200hzmatch
  import r200_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] addr,
  input  logic       uses,
  input  trk_t       e,
  input  trk_t       m,
  input  trk_t       w,
  output logic [1:0] fwdsel,
  output logic       loadhit
);

  always_comb begin
    fwdsel  = FWD_RF;
    loadhit = 1'b0;
    if (trk_hit(e, addr, uses, id_valid)) begin
      if (e.isload) loadhit = 1'b1;
      else          fwdsel  = FWD_EX;
    end else if (trk_hit(m, addr, uses, id_valid)) begin
      fwdsel = FWD_MEM;
    end else if (trk_hit(w, addr, uses, id_valid)) begin
      fwdsel = FWD_WB;
    end
  end

endmodule

// File: rtl/r200hazctl.sv
// r200 interlock/forwarding controller: tracks EX/MEM/WB destinations and
// produces forwarding selects, load-use stalls, busy freezes and flushes.
module r200hazctl
  import r200_pkg::*;
(
  input logic         clk,
  input logic         rst,
  r200hazctl_if.slave hz
);

  trk_t       e_q, m_q, w_q, id_trk;
  logic       br_pend;
  logic [1:0] fwd1, fwd2;
  logic       lh1, lh2, loaduse;
  logic       br_req, br_flush, flush_id_c, flush_if_c, stall_c;

  r200hzmatch u_match1 (
    .id_valid (hz.id_valid),
    .addr     (hz.id_rs1addr),
    .uses     (hz.id_uses_rs1),
    .e        (e_q),
    .m        (m_q),
    .w        (w_q),
    .fwdsel   (fwd1),
    .loadhit  (lh1)
  );

  r200hzmatch u_match2 (
    .id_valid (hz.id_valid),
    .addr     (hz.id_rs2addr),
    .uses     (hz.id_uses_rs2),
    .e        (e_q),
    .m        (m_q),
    .w        (w_q),
    .fwdsel   (fwd2),
    .loadhit  (lh2)
  );

  always_comb begin
    loaduse    = lh1 | lh2;
    br_req     = hz.ex_brtaken | br_pend;
    br_flush   = br_req & ~hz.mem_busy;
    flush_id_c = br_flush | (loaduse & ~hz.mem_busy);
    flush_if_c = (br_req | (hz.id_willjmp & hz.id_valid & ~loaduse)) & ~hz.mem_busy;
    // a branch flush squashes the stalled ID instruction, so the stall drops
    stall_c    = hz.mem_busy | (loaduse & ~br_flush);
    // any flush_id (branch or load-use bubble) enters EX as an invalid slot
    id_trk     = '{valid:  hz.id_valid & ~flush_id_c,
                   rd:     hz.id_rdaddr,
                   regwr:  hz.id_regwr,
                   isload: hz.id_isload};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      br_pend <= 1'b0;
    end else if (!hz.mem_busy) begin
      e_q     <= id_trk;
      m_q     <= e_q;
      w_q     <= m_q;
      br_pend <= 1'b0;
    end else begin
      br_pend <= br_pend | hz.ex_brtaken;
    end
  end

  assign hz.stall_if = ~rst & stall_c;
  assign hz.stall_id = ~rst & stall_c;
  assign hz.flush_if = ~rst & flush_if_c;
  assign hz.flush_id = ~rst & flush_id_c;
  assign hz.fwd1sel  = rst ? '0 : fwd1;
  assign hz.fwd2sel  = rst ? '0 : fwd2;

endmodule
